// File: rtl/decoder_2dr_rr_sched.sv
// decoder_2dr_rr_sched
// Round-robin scheduler sharing one dual-rail-input, one-hot-output decoder
// among N = 2**SIZE requesters. The winner's index is driven to the decoder as
// a dual-rail code for one cycle, the clocked one-hot reply is awaited, and a
// one-cycle grant is returned to the winner.
//
// Optional feature macro: DECODER_SCHED_CHECK_EN
//   defined   : one-hot reply compare, timeout, err pulse, warning message
//   undefined : WAIT lasts exactly DEC_LAT cycles, dec_out ignored, err = 0
//
// Parameters:
//   warning_file  tag for mismatch/timeout messages ("" = no message output)
//   SIZE          decoder address bits
//   DEC_LAT       decoder latency in cycles (code-present cycle to one-hot out)
//   TIMEOUT       max WAIT cycles before the decoder is declared dead (> DEC_LAT)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        request pulses, bit i = requester i
//   dec_in     dual-rail code, [b][0] = bit b is 1, [b][1] = bit b is 0, 00 = spacer
//   dec_valid  high in the cycle dec_in carries a code
//   dec_out    one-hot reply from decoder
//   grant      one-hot, one-cycle grant
//   busy       scheduler not idle
//   err        one-cycle pulse on mismatch/timeout
module decoder_2dr_rr_sched #(
    parameter string       warning_file = "",
    parameter int unsigned SIZE         = 2,
    parameter int unsigned DEC_LAT      = 1,
    parameter int unsigned TIMEOUT      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [(1 << SIZE)-1:0]    req,
    output logic [SIZE-1:0][1:0]      dec_in,
    output logic                      dec_valid,
    input  logic [(1 << SIZE)-1:0]    dec_out,
    output logic [(1 << SIZE)-1:0]    grant,
    output logic                      busy,
    output logic                      err
);

    localparam int unsigned N     = 1 << SIZE;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + DEC_LAT + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GRANT
    } state_t;

    state_t            state;
    logic [N-1:0]      pend;
    logic [SIZE-1:0]   ptr;
    logic [SIZE-1:0]   sel;
    logic [CNT_W-1:0]  cnt;

    logic [SIZE-1:0]   win_c;
    logic [N-1:0]      sel_oh_c;
    logic [N-1:0]      clr_c;
    logic              to_grant_c;
    logic              to_fail_c;

    // First pending requester at or after ptr (wrapping); lowest offset wins.
    function automatic logic [SIZE-1:0] rr_pick(input logic [N-1:0]    p,
                                                input logic [SIZE-1:0] start);
        logic [SIZE-1:0] idx;
        rr_pick = start;
        for (int k = N - 1; k >= 0; k--) begin
            idx = start + SIZE'(k);
            if (p[idx]) rr_pick = idx;
        end
    endfunction

    // Binary index to dual-rail code: exactly one rail high per bit.
    function automatic logic [SIZE-1:0][1:0] dual_rail(input logic [SIZE-1:0] v);
        for (int b = 0; b < int'(SIZE); b++) begin
            dual_rail[b] = v[b] ? 2'b01 : 2'b10;
        end
    endfunction

`ifdef DECODER_SCHED_CHECK_EN
    // Report one warning line per failed decoder transaction.
    function automatic void log_fail(input logic [SIZE-1:0] s,
                                     input logic [N-1:0]    d);
        if (warning_file != "") begin
            $display("%0t decoder_2dr_rr_sched [%s]: decoder fault sel=%0d dec_out=%b",
                     $time, warning_file, s, d);
        end
    endfunction
`else
    // Reply and log path are absent in this build.
    logic unused_dec_out;
    assign unused_dec_out = ^dec_out;
    localparam bit unused_log_path = (warning_file != "");
`endif

    // Winner selection and WAIT-state exit decisions.
    always_comb begin
        win_c      = rr_pick(pend, ptr);
        sel_oh_c   = N'(1) << sel;
        to_grant_c = 1'b0;
        to_fail_c  = 1'b0;
        if (state == ST_WAIT) begin
`ifdef DECODER_SCHED_CHECK_EN
            if (dec_out != '0) begin
                if (dec_out == sel_oh_c) to_grant_c = 1'b1;
                else                     to_fail_c  = 1'b1;
            end else if ((cnt + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
                to_fail_c = 1'b1;
            end
`else
            if (cnt == CNT_W'(DEC_LAT - 1)) to_grant_c = 1'b1;
`endif
        end
        clr_c = to_grant_c ? sel_oh_c : '0;
    end

    // Scheduler FSM, pending set and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pend      <= '0;
            ptr       <= '0;
            sel       <= '0;
            cnt       <= '0;
            dec_in    <= '0;
            dec_valid <= 1'b0;
            grant     <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // A same-edge request re-arms the bit being granted.
            pend      <= (pend & ~clr_c) | req;
            dec_in    <= '0;
            dec_valid <= 1'b0;
            grant     <= '0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pend != '0) begin
                        sel       <= win_c;
                        dec_in    <= dual_rail(win_c);
                        dec_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (to_grant_c) begin
                        grant <= sel_oh_c;
                        ptr   <= sel + SIZE'(1);
                        state <= ST_GRANT;
                    end else if (to_fail_c) begin
                        // Request stays pending and is retried from IDLE.
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
`ifdef DECODER_SCHED_CHECK_EN
                        log_fail(sel, dec_out);
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GRANT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_2dr_rr_sched.sv
// Directed bench for decoder_2dr_rr_sched (SIZE=2, DEC_LAT=1, TIMEOUT=4)
// with a behavioural one-cycle decoder model that can be made silent or
// forced to a fixed reply.
module tb_decoder_2dr_rr_sched;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      req = '0;
    logic [1:0][1:0] dec_in;
    logic            dec_valid;
    logic [3:0]      dec_out;
    logic [3:0]      grant;
    logic            busy;
    logic            err;

    // 0 = correct decoder, 1 = silent, 2 = fixed reply on valid, 3 = stuck output
    int              mode = 0;
    logic [3:0]      force_val = '0;
    logic [1:0]      code;

    int n_tests = 0;
    int n_fail  = 0;

    decoder_2dr_rr_sched #(
        .warning_file (""),
        .SIZE         (2),
        .DEC_LAT      (1),
        .TIMEOUT      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dec_in    (dec_in),
        .dec_valid (dec_valid),
        .dec_out   (dec_out),
        .grant     (grant),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Decoder model: rail [0] of each bit carries the 1 value.
    always_comb begin
        code[0] = dec_in[0][0];
        code[1] = dec_in[1][0];
    end

    always @(posedge clk) begin
        case (mode)
            0:       dec_out <= dec_valid ? (4'b0001 << code) : 4'b0000;
            1:       dec_out <= 4'b0000;
            2:       dec_out <= dec_valid ? force_val : 4'b0000;
            default: dec_out <= force_val;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    // Waits (bounded) for a grant; checks its value and its latency in cycles.
    task automatic wait_grant(input string tag, input logic [3:0] exp, input int exp_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == 4'b0000 && n < 20);
        check(tag, 32'(grant), 32'(exp));
        check({tag, "_lat"}, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        logic [3:0] seen;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_dec_in",    32'(dec_in),    32'h0);
        check("rst_dec_valid", 32'(dec_valid), 32'h0);
        check("rst_grant",     32'(grant),     32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_err",       32'(err),       32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single request 0100: code for index 2, grant three edges after the sampling edge
        req = 4'b0100;
        tick();                                   // E0
        req = 4'b0000;
        check("s_pend",  32'(dut.pend), 32'h4);
        check("s_busy0", 32'(busy),     32'h0);
        tick();                                   // E1 -> ISSUE
        check("s_valid", 32'(dec_valid), 32'h1);
        check("s_dec_in", 32'(dec_in),   32'b0110);
        check("s_busy1", 32'(busy),      32'h1);
        tick();                                   // E2 -> WAIT
        check("s_spacer", 32'(dec_in),    32'h0);
        check("s_valid0", 32'(dec_valid), 32'h0);
        tick();                                   // E3 -> GRANT
        check("s_grant", 32'(grant),    32'h4);
        check("s_ptr",   32'(dut.ptr),  32'h3);
        check("s_pend0", 32'(dut.pend), 32'h0);
        tick();                                   // E4 -> IDLE
        check("s_grant0", 32'(grant), 32'h0);
        check("s_busy2",  32'(busy),  32'h0);

        // All requesters at once from ptr=0
        apply_reset();
        req = 4'b1111;
        tick();
        req = 4'b0000;
        wait_grant("all_g0", 4'b0001, 3);
        wait_grant("all_g1", 4'b0010, 4);
        wait_grant("all_g2", 4'b0100, 4);
        wait_grant("all_g3", 4'b1000, 4);
        tick();
        check("all_pend", 32'(dut.pend), 32'h0);
        check("all_ptr",  32'(dut.ptr),  32'h0);
        check("all_busy", 32'(busy),     32'h0);

        // Fairness: requester 0 asks every cycle, requester 2 once
        req = 4'b0101;
        tick();
        req = 4'b0001;
        wait_grant("fair_g0", 4'b0001, 3);
        wait_grant("fair_g1", 4'b0100, 4);
        wait_grant("fair_g2", 4'b0001, 4);
        check("fair_ptr",   32'(dut.ptr),  32'h1);
        check("fair_pend0", 32'(dut.pend), 32'h1);
        apply_reset();
        check("fair_rst_pend", 32'(dut.pend), 32'h0);

`ifndef DECODER_SCHED_CHECK_EN
        // Silent decoder: grant after DEC_LAT regardless
        mode = 1;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        wait_grant("silent_g", 4'b0010, 3);
        check("silent_err", 32'(err), 32'h0);
        tick();
        mode = 0;
`else
        // Mismatch: reply 0010 for sel=3, then retry succeeds
        mode = 2;
        force_val = 4'b0010;
        req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        tick();
        tick();                                   // E3 evaluate
        check("mm_err",   32'(err),      32'h1);
        check("mm_grant", 32'(grant),    32'h0);
        check("mm_busy",  32'(busy),     32'h0);
        check("mm_pend",  32'(dut.pend), 32'h8);
        check("mm_ptr",   32'(dut.ptr),  32'h0);
        mode = 0;
        wait_grant("mm_retry", 4'b1000, 3);
        check("mm_err0", 32'(err), 32'h0);
        tick();

        // Timeout: silent decoder, err after 4 WAIT edges
        mode = 1;
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 5; i++) tick();
        check("to_err_early", 32'(err),  32'h0);
        check("to_busy_wait", 32'(busy), 32'h1);
        tick();
        check("to_err",  32'(err),      32'h1);
        check("to_busy", 32'(busy),     32'h0);
        check("to_pend", 32'(dut.pend), 32'h1);
        mode = 0;
        wait_grant("to_retry", 4'b0001, 3);
        tick();
`endif

        // Stuck decoder output while idle is ignored
        mode = 3;
        force_val = 4'b1000;
        seen = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | grant;
        end
        check("stuck_busy",  32'(busy),  32'h0);
        check("stuck_grant", 32'(seen),  32'h0);
        check("stuck_err",   32'(err),   32'h0);
        mode = 0;
        tick();

        // Async reset while in WAIT
        req = 4'b0011;
        tick();
        req = 4'b0000;
        tick();
        tick();
        check("ar_busy_wait", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("ar_busy",  32'(busy),      32'h0);
        check("ar_pend",  32'(dut.pend),  32'h0);
        check("ar_outs",  32'({dec_in, dec_valid, grant, err}), 32'h0);
        #2;
        rst = 1'b0;
        seen = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | grant;
        end
        check("ar_no_grant", 32'(seen), 32'h0);
        check("ar_idle",     32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
